// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, field-position, ALU-encoding and state definitions
// for the multi-cycle processor front end.
// Build option: HALT_EN adds the StHalt state.
package cpu_pkg;

   // Instruction field positions
   localparam int unsigned OP_MSB   = 31;
   localparam int unsigned OP_LSB   = 29;
   localparam int unsigned RD_MSB   = 28;
   localparam int unsigned RD_LSB   = 24;
   localparam int unsigned RS_MSB   = 23;
   localparam int unsigned RS_LSB   = 19;
   localparam int unsigned RT_MSB   = 18;
   localparam int unsigned RT_LSB   = 14;
   localparam int unsigned FUNC_MSB = 3;
   localparam int unsigned IMM_W    = 14;

   // Opcodes
   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_RTYPE = 3'b001;
   localparam logic [2:0] OP_ADDI  = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b100;
   localparam logic [2:0] OP_LUI   = 3'b101;
   localparam logic [2:0] OP_JUMP  = 3'b110;
   localparam logic [2:0] OP_BEQ   = 3'b111;

   // ALU function encodings
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_EQ  = 4'b1000;

   // Word that parks the front end when halting is built in
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      StFetch,
      StOperand,
      StIssue,
      StRelease
`ifdef HALT_EN
      ,
      StHalt
`endif
   } state_t;

   // Sign-extend the immediate field to a full word
   function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational field extraction, immediate sign extension,
// operand-B selection and ALU function selection.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rt_data,
   output logic [2:0]  op_code,
   output logic [4:0]  rd_add,
   output logic [4:0]  rs_add,
   output logic [4:0]  rt_add,
   output logic [31:0] imm_sext,
   output logic [31:0] operand_b,
   output logic [3:0]  alu_ctrl
);

   assign op_code  = instr[OP_MSB:OP_LSB];
   assign rd_add   = instr[RD_MSB:RD_LSB];
   assign rs_add   = instr[RS_MSB:RS_LSB];
   assign rt_add   = instr[RT_MSB:RT_LSB];
   assign imm_sext = sext_imm(instr[IMM_W-1:0]);

   // Select operand B and the ALU function from the opcode
   always_comb begin
      operand_b = imm_sext;
      alu_ctrl  = ALU_ADD;
      unique case (op_code)
         OP_NOP: begin
            operand_b = '0;
         end
         OP_RTYPE: begin
            operand_b = rt_data;
            alu_ctrl  = instr[FUNC_MSB:0];
         end
         OP_BEQ: begin
            operand_b = rt_data;
            alu_ctrl  = ALU_EQ;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/instruction_issue.sv
// instruction_issue: fetches the instruction at PC, decodes it, registers the
// operands and hands them to the result stage over enable/acknowledge, then
// loads PC from the result stage's new-PC value.
// Build option: HALT_EN makes 32'hFFFF_FFFF park the stage until reset.
module instruction_issue
   import cpu_pkg::*;
#(
   parameter int unsigned FETCH_WAIT = 3,
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int unsigned MEM_AW     = 11
) (
   input  logic              CLOCK_50,
   input  logic              resetIn,
   output logic [MEM_AW-1:0] fetchAdd,
   output logic              fetchRead,
   input  logic [31:0]       dataRead,
   output logic [4:0]        rsAdd,
   output logic [4:0]        rtAdd,
   input  logic [31:0]       rsData,
   input  logic [31:0]       rtData,
   output logic [31:0]       operandA,
   output logic [31:0]       operandB,
   output logic [3:0]        aluCtrl,
   output logic [2:0]        opCode,
   output logic [4:0]        RDadd,
   output logic [31:0]       PCold,
   output logic [31:0]       ADDout,
   output logic              enable,
   input  logic              acknowledge,
   input  logic [31:0]       PCnew,
   output logic              halted
);

   localparam int unsigned CNT_W = (FETCH_WAIT > 0) ? $clog2(FETCH_WAIT + 1) : 1;

   state_t           state;
   logic [CNT_W-1:0] fetch_cnt;
   logic [31:0]      pc;
   logic [31:0]      instr;

   logic [2:0]       dec_op;
   logic [4:0]       dec_rd;
   logic [31:0]      dec_imm;
   logic [31:0]      dec_operand_b;
   logic [3:0]       dec_alu_ctrl;

   instr_decoder u_decoder (
      .instr     (instr),
      .rt_data   (rtData),
      .op_code   (dec_op),
      .rd_add    (dec_rd),
      .rs_add    (rsAdd),
      .rt_add    (rtAdd),
      .imm_sext  (dec_imm),
      .operand_b (dec_operand_b),
      .alu_ctrl  (dec_alu_ctrl)
   );

   // Memory addresses wrap modulo 2^MEM_AW
   assign fetchAdd = pc[MEM_AW-1:0];

`ifndef HALT_EN
   assign halted = 1'b0;
`endif

   // Fetch/operand/issue/release sequencer with registered handshake outputs
   always_ff @(posedge CLOCK_50) begin
      if (resetIn) begin
         state     <= StFetch;
         fetch_cnt <= '0;
         pc        <= RESET_PC;
         instr     <= '0;
         fetchRead <= 1'b0;
         enable    <= 1'b0;
         operandA  <= '0;
         operandB  <= '0;
         aluCtrl   <= '0;
         opCode    <= '0;
         RDadd     <= '0;
         PCold     <= '0;
         ADDout    <= '0;
`ifdef HALT_EN
         halted    <= 1'b0;
`endif
      end else begin
         unique case (state)
            StFetch: begin
               // Address has been stable FETCH_WAIT+1 cycles on the last count
               if (fetch_cnt == CNT_W'(FETCH_WAIT)) begin
                  instr     <= dataRead;
                  fetch_cnt <= '0;
                  fetchRead <= 1'b0;
                  state     <= StOperand;
               end else begin
                  fetch_cnt <= fetch_cnt + CNT_W'(1);
                  fetchRead <= 1'b1;
               end
            end
            StOperand: begin
`ifdef HALT_EN
               if (instr == HALT_WORD) begin
                  halted <= 1'b1;
                  state  <= StHalt;
               end else begin
`endif
                  operandA <= rsData;
                  operandB <= dec_operand_b;
                  aluCtrl  <= dec_alu_ctrl;
                  opCode   <= dec_op;
                  RDadd    <= dec_rd;
                  PCold    <= pc;
                  ADDout   <= pc + 32'd1 + dec_imm;
                  enable   <= 1'b1;
                  state    <= StIssue;
`ifdef HALT_EN
               end
`endif
            end
            StIssue: begin
               // PCnew is only valid alongside the first acknowledge
               if (acknowledge) begin
                  pc     <= PCnew;
                  enable <= 1'b0;
                  state  <= StRelease;
               end
            end
            StRelease: begin
               if (!acknowledge) begin
                  fetch_cnt <= '0;
                  fetchRead <= 1'b1;
                  state     <= StFetch;
               end
            end
`ifdef HALT_EN
            StHalt: begin
               state <= StHalt;
            end
`endif
            default: begin
               state <= StFetch;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_issue.sv
// tb_instruction_issue: scoreboard bench. Each instruction placed in memory
// pushes its expected issue record; each enable rise pops and compares it.
module tb_instruction_issue;

   localparam int unsigned FW  = 3;
   localparam int unsigned AW  = 11;
   localparam logic [31:0] RPC = 32'h0;

   logic          CLOCK_50 = 1'b0;
   logic          resetIn;
   logic [AW-1:0] fetchAdd;
   logic          fetchRead;
   logic [31:0]   dataRead;
   logic [4:0]    rsAdd;
   logic [4:0]    rtAdd;
   logic [31:0]   rsData;
   logic [31:0]   rtData;
   logic [31:0]   operandA;
   logic [31:0]   operandB;
   logic [3:0]    aluCtrl;
   logic [2:0]    opCode;
   logic [4:0]    RDadd;
   logic [31:0]   PCold;
   logic [31:0]   ADDout;
   logic          enable;
   logic          acknowledge;
   logic [31:0]   PCnew;
   logic          halted;

   always #5 CLOCK_50 = ~CLOCK_50;

   instruction_issue #(
      .FETCH_WAIT (FW),
      .RESET_PC   (RPC),
      .MEM_AW     (AW)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .resetIn     (resetIn),
      .fetchAdd    (fetchAdd),
      .fetchRead   (fetchRead),
      .dataRead    (dataRead),
      .rsAdd       (rsAdd),
      .rtAdd       (rtAdd),
      .rsData      (rsData),
      .rtData      (rtData),
      .operandA    (operandA),
      .operandB    (operandB),
      .aluCtrl     (aluCtrl),
      .opCode      (opCode),
      .RDadd       (RDadd),
      .PCold       (PCold),
      .ADDout      (ADDout),
      .enable      (enable),
      .acknowledge (acknowledge),
      .PCnew       (PCnew),
      .halted      (halted)
   );

   // Memory with FW cycles of read latency
   logic [31:0] mem [1 << AW];
   logic [31:0] rd_pipe [FW];
   always @(posedge CLOCK_50) begin
      rd_pipe[0] <= mem[fetchAdd];
      for (int i = 1; i < FW; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign dataRead = rd_pipe[FW-1];

   // Combinational register file
   logic [31:0] regs [32];
   assign rsData = regs[rsAdd];
   assign rtData = regs[rtAdd];

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  alu;
      logic [31:0] pcold;
      logic [31:0] addout;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [13:0] imm);
      return {op, rd, rs, rt, imm};
   endfunction

   // Reference decode of one instruction at a given PC
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [31:0] simm;
      simm     = {{18{ins[13]}}, ins[13:0]};
      e.op     = ins[31:29];
      e.rd     = ins[28:24];
      e.a      = regs[ins[23:19]];
      e.pcold  = pc;
      e.addout = pc + 32'd1 + simm;
      case (e.op)
         3'b000:  begin e.b = 32'h0;            e.alu = 4'b0000;   end
         3'b001:  begin e.b = regs[ins[18:14]]; e.alu = ins[3:0];  end
         3'b111:  begin e.b = regs[ins[18:14]]; e.alu = 4'b1000;   end
         default: begin e.b = simm;             e.alu = 4'b0000;   end
      endcase
      return e;
   endfunction

   task automatic load(input logic [31:0] pc, input logic [31:0] ins);
      mem[pc[AW-1:0]] = ins;
      sb.push_back(model(ins, pc));
   endtask

   // Called in the first FETCH cycle; counts edges until enable is seen
   task automatic wait_enable(output int cyc);
      cyc = 0;
      while (!enable && cyc < 40) begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
      end
      if (!enable) check_val("enable_timeout", 32'd0, 32'd1);
   endtask

   task automatic compare_issue();
      exp_t e;
      if (sb.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check_val("opCode",   32'(opCode),  32'(e.op));
      check_val("RDadd",    32'(RDadd),   32'(e.rd));
      check_val("operandA", operandA,     e.a);
      check_val("operandB", operandB,     e.b);
      check_val("aluCtrl",  32'(aluCtrl), 32'(e.alu));
      check_val("PCold",    PCold,        e.pcold);
      check_val("ADDout",   ADDout,       e.addout);
   endtask

   // Called in an ISSUE cycle; acknowledges for 'hold' cycles, returns in FETCH
   task automatic do_ack(input logic [31:0] pcn, input int hold);
      logic [AW-1:0] fa;
      fa          = pcn[AW-1:0];
      acknowledge = 1'b1;
      PCnew       = pcn;
      @(posedge CLOCK_50);
      #1;
      PCnew = 32'hDEAD_BEEF;
      check_val("enable_drop", 32'(enable), 32'd0);
      check_val("pc_load", 32'(fetchAdd), 32'(fa));
      for (int i = 1; i < hold; i++) begin
         @(posedge CLOCK_50);
         #1;
         check_val("hold_pc", 32'(fetchAdd), 32'(fa));
         check_val("hold_fetchRead", 32'(fetchRead), 32'd0);
      end
      acknowledge = 1'b0;
      PCnew       = 32'h0;
      @(posedge CLOCK_50);
      #1;
      check_val("fetch_start", 32'(fetchRead), 32'd1);
   endtask

   int cyc;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
      resetIn     = 1'b1;
      acknowledge = 1'b0;
      PCnew       = 32'h0;

      // op 001, rd 2, rs 1, rt 1, func 0001
      regs[1] = 32'd5;
      load(32'h0, enc(3'd1, 5'd2, 5'd1, 5'd1, 14'h0001));

      repeat (3) @(posedge CLOCK_50);
      #1;
      check_val("rst_enable",    32'(enable),    32'd0);
      check_val("rst_fetchRead", 32'(fetchRead), 32'd0);
      check_val("rst_halted",    32'(halted),    32'd0);
      check_val("rst_operandA",  operandA,       32'd0);
      check_val("rst_operandB",  operandB,       32'd0);
      check_val("rst_PCold",     PCold,          32'd0);
      check_val("rst_ADDout",    ADDout,         32'd0);
      check_val("rst_fetchAdd",  32'(fetchAdd),  32'(RPC[AW-1:0]));
      resetIn = 1'b0;

      wait_enable(cyc);
      check_val("latency_reset", 32'(cyc), FW + 2);
      check_val("fetchAdd_hold", 32'(fetchAdd), 32'd0);
      compare_issue();

      // op 010 at PC 7, imm -2 -> ADDout 6
      regs[2] = 32'd100;
      load(32'd7, enc(3'd2, 5'd3, 5'd2, 5'd0, 14'h3FFE));
      do_ack(32'd7, 1);
      wait_enable(cyc);
      check_val("latency", 32'(cyc), FW + 2);
      compare_issue();

      // op 000 still carries rsData on operand A
      regs[3] = 32'h55;
      load(32'd6, enc(3'd0, 5'd4, 5'd3, 5'd2, 14'h0123));
      do_ack(32'd6, 1);
      wait_enable(cyc);
      compare_issue();

      // Branch compare, reached through an acknowledge held for 5 cycles
      regs[4] = 32'd9;
      regs[5] = 32'd9;
      load(32'h20, enc(3'd7, 5'd0, 5'd4, 5'd5, 14'h0010));
      do_ack(32'h20, 5);
      wait_enable(cyc);
      check_val("latency_hold", 32'(cyc), FW + 2);
      compare_issue();

      // Positive immediate at the top of memory
      regs[6] = 32'hFFFF_FFFF;
      regs[7] = 32'd3;
      load(32'h7FF, enc(3'd3, 5'd5, 5'd6, 5'd7, 14'h1FFF));
      do_ack(32'h7FF, 1);
      wait_enable(cyc);
      compare_issue();

      // PC 0x800 fetches from address 0 but keeps the full PC
      sb.push_back(model(mem[0], 32'h800));
      do_ack(32'h800, 1);
      wait_enable(cyc);
      compare_issue();

      // Reset in ISSUE with a simultaneous acknowledge
      resetIn     = 1'b1;
      acknowledge = 1'b1;
      PCnew       = 32'h123;
      @(posedge CLOCK_50);
      #1;
      check_val("rst_issue_enable",   32'(enable),   32'd0);
      check_val("rst_issue_fetchAdd", 32'(fetchAdd), 32'(RPC[AW-1:0]));
      check_val("rst_issue_PCold",    PCold,         32'd0);
      resetIn     = 1'b0;
      acknowledge = 1'b0;
      PCnew       = 32'h0;
      sb.push_back(model(mem[0], RPC));
      wait_enable(cyc);
      check_val("latency_rst_issue", 32'(cyc), FW + 2);
      compare_issue();

`ifdef HALT_EN
      mem[32'h40] = 32'hFFFF_FFFF;
      do_ack(32'h40, 1);
      cyc = 0;
      while (!halted && cyc < 20) begin
         @(posedge CLOCK_50);
         #1;
         cyc++;
      end
      check_val("halted", 32'(halted), 32'd1);
      begin
         int bad;
         bad = 0;
         repeat (20) begin
            @(posedge CLOCK_50);
            #1;
            if (enable || fetchRead || !halted || fetchAdd != AW'(32'h40)) bad++;
         end
         check_val("halt_quiet", 32'(bad), 32'd0);
      end
`else
      // All-ones word is an ordinary branch without halting built in
      load(32'h40, 32'hFFFF_FFFF);
      do_ack(32'h40, 1);
      wait_enable(cyc);
      compare_issue();
      check_val("halted_tied", 32'(halted), 32'd0);
      do_ack(32'h0, 1);
`endif

      check_val("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
